mod_arith_unit: RTL and testbench
=================================

// Module: mod_arith_unit
// PURPOSE
//  Parametrised sequential modular arithmetic unit, successor to the fixed mod-11 4-bit adder/subtractor.
//  Computes z = (x op y) mod MODULUS for op in {add, sub, mul}; operands must already be in [0, MODULUS).
//  Valid/ready handshake on input and output; one operation in flight; sits between operand source and result sink.
// PARAMETERS
//  WIDTH    4   operand/result width in bits
//  MODULUS  11  modulus; legal range 2 <= MODULUS <= 2**WIDTH (elaboration-time check, $error if violated)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      unit can accept (registered)
//  op         in   2      00 add, 01 sub, 10 mul, 11 reserved
//  x          in   WIDTH  operand x
//  y          in   WIDTH  operand y
//  out_valid  out  1      z/err valid (registered)
//  out_ready  in   1      sink accepts result
//  z          out  WIDTH  result, always < MODULUS when err=0
//  err        out  1      1 = operand out of range or reserved op; z forced 0
// BEHAVIOUR
//  - Reset (async assert, sync deassert at the flops): state=IDLE, in_ready=0, out_valid=0, z=0, err=0, acc=0.
//    in_ready rises on the first clk edge with rst_n high.
//  - FSM: IDLE -> (accept) -> MUL or DONE; MUL -> DONE after WIDTH cycles; DONE -> (out_valid&&out_ready) -> IDLE.
//  - Accept = in_valid && in_ready, sampled at an edge; the same edge clears in_ready and captures x, y, op.
//  - Errors: x>=MODULUS, y>=MODULUS, or op==11 -> DONE next edge, err=1, z=0, no computation. Latency 1.
//  - add: s = x+y in WIDTH+1 bits; z = (s>=MODULUS) ? s-MODULUS : s. DONE next edge. Latency 1.
//  - sub: d = x-y in WIDTH+1 bits; on borrow z = d+MODULUS, else z = d. Latency 1.
//  - mul: MSB-first double-and-add, one bit of y per cycle, i = WIDTH-1 down to 0:
//      acc = 2*acc mod M (one conditional subtract); if y[i], acc = (acc+x) mod M (one conditional subtract).
//      All intermediates are WIDTH+1 bits, no wider multiplier. out_valid rises WIDTH edges after accept.
//  - DONE: out_valid=1; z/err held stable until out_valid&&out_ready.
//    On that edge out_valid->0 and in_ready->1 (IDLE). No accept in the same cycle as the output handshake,
//    so back-to-back throughput is one op per latency+2 cycles.
//  - in_valid/op/x/y are ignored while in_ready=0. in_valid may drop without acceptance; no side effect.
//  - out_ready is ignored while out_valid=0.
//  - Reset mid-operation (MUL or DONE): op aborted, result discarded, no out_valid, values as at reset.
//  - MODULUS == 2**WIDTH is legal: range checks then never fire; sums still use the WIDTH+1-bit compare.
// TESTING
//  1. W=4,M=11 exhaustive: x,y in 0..10, ops add/sub/mul (363 ops). Each result matches the integer model;
//     report pass count 363/363.
//  2. add x=7,y=9 -> z=5, err=0, out_valid 1 cycle after accept. sub x=3,y=8 -> z=6. sub x=8,y=3 -> z=5.
//  3. mul x=7,y=9 -> z=8 (63 mod 11), out_valid exactly 4 cycles after accept; in_ready=0 throughout.
//  4. x=11,y=2 add -> err=1, z=0, latency 1. op=11 with x=1,y=1 -> err=1. Next legal op is unaffected.
//  5. Backpressure: mul 10*10 with out_ready=0 for 5 cycles -> z=1 held stable, out_valid held.
//     in_ready=0 until the cycle after out_ready=1.
//  6. rst_n pulsed low during cycle 2 of mul -> all outputs 0 immediately, no out_valid afterwards.
//     Second build W=8,M=251: mul 250*250 -> z=1 after 8 cycles. add 200+100 -> z=49.

Source files
------------

// File: rtl/mod_arith_unit.sv
// Sequential modular arithmetic unit computing z = (x op y) mod MODULUS for
// add, sub and mul. Input and output use valid/ready handshakes, and only one
// operation is in flight at a time. Add, sub and error results appear one edge
// after accept. Multiply uses MSB-first double-and-add and takes WIDTH edges.
module mod_arith_unit #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             err
);

  // Multiply bit counter: indexes y from WIDTH-1 down to 0.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // The modulus is held in WIDTH+1 bits so that MODULUS == 2**WIDTH still fits.
  localparam logic [WIDTH:0] MOD_W = (WIDTH + 1)'(MODULUS);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  // Reject illegal moduli when the design is elaborated.
  if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
    $error("mod_arith_unit: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_MUL, S_DONE} state_t;

  state_t             state_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   z_reg;
  logic               err_reg;
  logic [WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]   x_reg;
  logic [WIDTH-1:0]   y_reg;
  logic [1:0]         op_reg;
  logic [CNT_W-1:0]   cnt_reg;

  // Operand out of range or reserved opcode.
  function automatic logic is_bad(input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b,
                                  input logic [1:0]       o);
    return ({1'b0, a} >= MOD_W) || ({1'b0, b} >= MOD_W) || (o == 2'b11);
  endfunction

  logic             accept;
  logic             in_bad;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             eval_err;
  logic [WIDTH-1:0] eval_z;
  logic [WIDTH:0]   dbl_ext;
  logic [WIDTH:0]   dbl_mod;
  logic [WIDTH:0]   dadd_ext;
  logic [WIDTH-1:0] mul_next;

  assign accept = (state_reg == S_IDLE) && in_ready_reg && in_valid;
  assign in_bad = is_bad(x, y, op);

  // Single-cycle add/sub result on the captured operands.
  always_comb begin
    sum_ext  = {1'b0, x_reg} + {1'b0, y_reg};
    diff_ext = {1'b0, x_reg} - {1'b0, y_reg};
    eval_err = is_bad(x_reg, y_reg, op_reg);
    eval_z   = '0;
    if (!eval_err) begin
      case (op_reg)
        OP_ADD:  eval_z = (sum_ext >= MOD_W) ? WIDTH'(sum_ext - MOD_W) : WIDTH'(sum_ext);
        // diff_ext[WIDTH] is the borrow out of the subtraction.
        OP_SUB:  eval_z = diff_ext[WIDTH] ? WIDTH'(diff_ext + MOD_W) : WIDTH'(diff_ext);
        default: eval_z = '0;
      endcase
    end
  end

  // One double-and-add step. All intermediates stay below 2*MODULUS, so they fit in WIDTH+1 bits.
  always_comb begin
    dbl_ext  = {acc_reg, 1'b0};
    dbl_mod  = (dbl_ext >= MOD_W) ? (dbl_ext - MOD_W) : dbl_ext;
    dadd_ext = dbl_mod + {1'b0, x_reg};
    mul_next = WIDTH'(dbl_mod);
    if (y_reg[cnt_reg]) begin
      mul_next = (dadd_ext >= MOD_W) ? WIDTH'(dadd_ext - MOD_W) : WIDTH'(dadd_ext);
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      z_reg         <= '0;
      err_reg       <= 1'b0;
      acc_reg       <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      op_reg        <= OP_ADD;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          in_ready_reg <= 1'b1;
          if (accept) begin
            in_ready_reg <= 1'b0;
            x_reg        <= x;
            y_reg        <= y;
            op_reg       <= op;
            acc_reg      <= '0;
            cnt_reg      <= CNT_LAST;
            // Errors always take the one-cycle path, even for a multiply.
            state_reg    <= (!in_bad && (op == OP_MUL)) ? S_MUL : S_EVAL;
          end
        end
        S_EVAL: begin
          z_reg         <= eval_z;
          err_reg       <= eval_err;
          out_valid_reg <= 1'b1;
          state_reg     <= S_DONE;
        end
        S_MUL: begin
          acc_reg <= mul_next;
          if (cnt_reg == '0) begin
            z_reg         <= mul_next;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        S_DONE: begin
          // Result stays stable until the sink takes it. No new accept happens on this edge.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign z         = z_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mod_arith_unit.sv
// Directed bench for mod_arith_unit. Instance a is W=4/M=11 and instance b is W=8/M=251.
// Both instances share rst_n, op and out_ready. Each has its own in_valid.
module tb_mod_arith_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_a, in_valid_b;
  logic       in_ready_a, in_ready_b;
  logic [1:0] op;
  logic [3:0] xa, ya, za;
  logic [7:0] xb, yb, zb;
  logic       out_valid_a, out_valid_b;
  logic       out_ready;
  logic       err_a, err_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_arith_unit #(.WIDTH(4), .MODULUS(11)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .op(op), .x(xa), .y(ya), .out_valid(out_valid_a), .out_ready(out_ready),
    .z(za), .err(err_a)
  );

  mod_arith_unit #(.WIDTH(8), .MODULUS(251)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .op(op), .x(xb), .y(yb), .out_valid(out_valid_b), .out_ready(out_ready),
    .z(zb), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one full transaction on instance a (sel=0) or b (sel=1) and checks the result and the latency.
  task automatic run_op(input bit sel, input logic [1:0] o, input logic [7:0] xv,
                        input logic [7:0] yv, input logic [7:0] exp_z,
                        input logic exp_err, input int exp_lat, input string tag);
    int         waitc = 0;
    int         lat   = 0;
    bit         saw_ready = 1'b0;
    logic [7:0] zr;
    logic       er;
    while (!(sel ? in_ready_b : in_ready_a) && waitc < 50) begin
      @(posedge clk); #1; waitc++;
    end
    check({tag, "_rdy"}, {31'd0, (sel ? in_ready_b : in_ready_a)}, 32'd1);
    op = o;
    if (sel) begin xb = xv; yb = yv; in_valid_b = 1'b1; end
    else begin xa = xv[3:0]; ya = yv[3:0]; in_valid_a = 1'b1; end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    while (!(sel ? out_valid_b : out_valid_a) && lat < 50) begin
      @(posedge clk); #1; lat++;
      if (sel ? in_ready_b : in_ready_a) saw_ready = 1'b1;
    end
    zr = sel ? zb : {4'd0, za};
    er = sel ? err_b : err_a;
    check({tag, "_z"}, {24'd0, zr}, {24'd0, exp_z});
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, {31'd0, saw_ready}, 32'd0);
    $display("%s: sel=%0d op=%0d x=%0d y=%0d z=%0d err=%0d lat=%0d",
             tag, sel, o, xv, yv, zr, er, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovclr"}, {31'd0, (sel ? out_valid_b : out_valid_a)}, 32'd0);
  endtask

  // Bounds the whole run so it cannot hang.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    bit         ov_seen;
    logic [7:0] ez;
    rst_n = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready = 1'b0;
    op = 2'b00; xa = '0; ya = '0; xb = '0; yb = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("rst_z", {28'd0, za}, 32'd0);
    check("rst_err", {31'd0, err_a}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, in_ready_a}, 32'd0);
    @(posedge clk); #1;
    check("first_in_ready", {31'd0, in_ready_a}, 32'd1);

    // Directed cases.
    run_op(1'b0, 2'b00, 8'd7, 8'd9, 8'd5, 1'b0, 1, "add_7_9");
    run_op(1'b0, 2'b01, 8'd3, 8'd8, 8'd6, 1'b0, 1, "sub_3_8");
    run_op(1'b0, 2'b01, 8'd8, 8'd3, 8'd5, 1'b0, 1, "sub_8_3");
    run_op(1'b0, 2'b10, 8'd7, 8'd9, 8'd8, 1'b0, 4, "mul_7_9");
    run_op(1'b0, 2'b00, 8'd11, 8'd2, 8'd0, 1'b1, 1, "err_x11");
    run_op(1'b0, 2'b11, 8'd1, 8'd1, 8'd0, 1'b1, 1, "err_op3");
    run_op(1'b0, 2'b00, 8'd1, 8'd2, 8'd3, 1'b0, 1, "after_err");
    run_op(1'b0, 2'b10, 8'd3, 8'd12, 8'd0, 1'b1, 1, "err_mul_y");

    // Every legal operand pair for add, sub and mul at M=11.
    for (int o = 0; o < 3; o++) begin
      for (int i = 0; i < 11; i++) begin
        for (int j = 0; j < 11; j++) begin
          if (o == 0)      ez = 8'((i + j) % 11);
          else if (o == 1) ez = 8'((i - j + 11) % 11);
          else             ez = 8'((i * j) % 11);
          run_op(1'b0, 2'(o), 8'(i), 8'(j), ez, 1'b0, (o == 2) ? 4 : 1, "exh");
        end
      end
    end

    // Backpressure: the result must stay stable while the sink stalls.
    op = 2'b10; xa = 4'd10; ya = 4'd10; in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    lat = 0;
    while (!out_valid_a && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp_lat", lat, 4);
    for (int k = 0; k < 5; k++) begin
      check("bp_z", {28'd0, za}, 32'd1);
      check("bp_ov", {31'd0, out_valid_a}, 32'd1);
      check("bp_rdy", {31'd0, in_ready_a}, 32'd0);
      $display("bp stall cycle=%0d z=%0d out_valid=%0d", k, za, out_valid_a);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check("bp_rdy_hs", {31'd0, in_ready_a}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_ov_after", {31'd0, out_valid_a}, 32'd0);
    check("bp_rdy_after", {31'd0, in_ready_a}, 32'd1);

    // Reset in the middle of a multiply aborts it.
    op = 2'b10; xa = 4'd7; ya = 4'd9; in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", {31'd0, out_valid_a}, 32'd0);
    check("mid_rst_rdy", {31'd0, in_ready_a}, 32'd0);
    check("mid_rst_z", {28'd0, za}, 32'd0);
    check("mid_rst_err", {31'd0, err_a}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ov_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (out_valid_a) ov_seen = 1'b1;
    end
    check("mid_rst_no_ov", {31'd0, ov_seen}, 32'd0);
    $display("mid-op reset: out_valid seen afterwards=%0d", ov_seen);

    // Wider build: W=8, M=251.
    run_op(1'b1, 2'b10, 8'd250, 8'd250, 8'd1, 1'b0, 8, "b_mul");
    run_op(1'b1, 2'b00, 8'd200, 8'd100, 8'd49, 1'b0, 1, "b_add");
    run_op(1'b1, 2'b01, 8'd5, 8'd10, 8'd246, 1'b0, 1, "b_sub");
    run_op(1'b1, 2'b00, 8'd251, 8'd0, 8'd0, 1'b1, 1, "b_err");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
